// File: rtl/data_mem_responder.sv
// ---------------------------------------------------------------------------
// data_mem_responder
//
// Single-port data memory that answers one request at a time through a
// valid/ready request channel and a valid/ready response channel. Each access
// spends LATENCY cycles in BUSY before its response is presented.
//
// Parameters
//    ADDR_W   word-address width; the array holds 2**ADDR_W 32-bit words
//             (the range check below assumes ADDR_W <= 29)
//    LATENCY  BUSY cycles per access, 0..15
//
// Ports
//    CLK        clock, rising-edge
//    RSTn       asynchronous active-low reset
//    ReqValid   request present
//    ReqReady   responder idle and able to accept
//    ReqAddr    byte address, bits [1:0] ignored
//    ReqWrite   1 = write, 0 = read
//    ReqStrb    byte-lane write enables
//    ReqWData   lane-positioned write data
//    RspValid   response present
//    RspReady   initiator accepts response
//    RspRData   read word, 0 for writes and range errors
//    RspErr     out-of-range access flag
//
// Build option
//    DMRESP_RANGE_ERR_EN  when defined, any request with ReqAddr[31:ADDR_W+2]
//                         nonzero completes with RspErr=1, RspRData=0 and no
//                         memory write. When undefined, RspErr is 0 and the
//                         high address bits are ignored (addresses wrap).
//
// State table
//    state   | meaning
//    IDLE    | ReqReady=1, waiting for a request
//    BUSY    | counting down the access latency
//    RESP    | response held until RspReady
// ---------------------------------------------------------------------------
module data_mem_responder #(
    parameter int ADDR_W  = 10,
    parameter int LATENCY = 2
) (
    input  logic        CLK,
    input  logic        RSTn,
    input  logic        ReqValid,
    output logic        ReqReady,
    input  logic [31:0] ReqAddr,
    input  logic        ReqWrite,
    input  logic [3:0]  ReqStrb,
    input  logic [31:0] ReqWData,
    output logic        RspValid,
    input  logic        RspReady,
    output logic [31:0] RspRData,
    output logic        RspErr
);

    localparam int         DEPTH    = 2 ** ADDR_W;
    localparam bit         LAT_ZERO = (LATENCY == 0);
    localparam logic [3:0] CNT_LOAD = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] addr_q, addr_d;
    logic        write_q, write_d;
    logic [3:0]  strb_q, strb_d;
    logic [31:0] wdata_q, wdata_d;
    logic        ready_q, ready_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;

    logic [31:0] mem [DEPTH];

    logic              accept;
    logic              access_now;
    logic [31:0]       acc_addr;
    logic              acc_write;
    logic [3:0]        acc_strb;
    logic [31:0]       acc_wdata;
    logic [ADDR_W-1:0] acc_idx;
    logic              acc_range_err;
    logic [31:0]       rd_word;
    logic              mem_we;
    logic              unused_addr_bits;

    assign accept = ReqValid & ready_q;

    // With zero latency the access happens on the accept edge itself, so the
    // live request inputs feed the array; otherwise the latched copy does.
    assign acc_addr  = (state_q == ST_IDLE) ? ReqAddr  : addr_q;
    assign acc_write = (state_q == ST_IDLE) ? ReqWrite : write_q;
    assign acc_strb  = (state_q == ST_IDLE) ? ReqStrb  : strb_q;
    assign acc_wdata = (state_q == ST_IDLE) ? ReqWData : wdata_q;
    assign acc_idx   = acc_addr[ADDR_W+1:2];

    assign access_now = ((state_q == ST_BUSY) && (cnt_q == 4'd0)) ||
                        (LAT_ZERO && accept);

`ifdef DMRESP_RANGE_ERR_EN
    assign acc_range_err    = |acc_addr[31:ADDR_W+2];
    assign unused_addr_bits = ^acc_addr[1:0];
`else
    assign acc_range_err    = 1'b0;
    assign unused_addr_bits = ^{acc_addr[31:ADDR_W+2], acc_addr[1:0]};
`endif

    assign rd_word = mem[acc_idx];

    // RSTn gate keeps a zero-latency build from writing while held in reset,
    // when the idle decode would otherwise see a request as accepted.
    assign mem_we = access_now & acc_write & ~acc_range_err & RSTn;

    // Array is deliberately outside the reset domain; contents survive reset.
    always_ff @(posedge CLK) begin
        if (mem_we) begin
            for (int b = 0; b < 4; b++) begin
                if (acc_strb[b]) begin
                    mem[acc_idx][8*b +: 8] <= acc_wdata[8*b +: 8];
                end
            end
        end
    end

    // State register and registered outputs
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state_q     <= ST_IDLE;
            cnt_q       <= 4'd0;
            addr_q      <= 32'd0;
            write_q     <= 1'b0;
            strb_q      <= 4'd0;
            wdata_q     <= 32'd0;
            ready_q     <= 1'b1;
            rsp_valid_q <= 1'b0;
            rdata_q     <= 32'd0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            addr_q      <= addr_d;
            write_q     <= write_d;
            strb_q      <= strb_d;
            wdata_q     <= wdata_d;
            ready_q     <= ready_d;
            rsp_valid_q <= rsp_valid_d;
            rdata_q     <= rdata_d;
            err_q       <= err_d;
        end
    end

    // Next-state and request capture
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        write_d = write_q;
        strb_d  = strb_q;
        wdata_d = wdata_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    addr_d  = ReqAddr;
                    write_d = ReqWrite;
                    strb_d  = ReqStrb;
                    wdata_d = ReqWData;
                    if (LAT_ZERO) begin
                        state_d = ST_RESP;
                    end else begin
                        state_d = ST_BUSY;
                        cnt_d   = CNT_LOAD;
                    end
                end
            end
            ST_BUSY: begin
                if (cnt_q == 4'd0) begin
                    state_d = ST_RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_RESP: begin
                if (RspReady) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = 4'd0;
            end
        endcase
    end

    // Output decode and response capture
    always_comb begin
        ready_d     = (state_d == ST_IDLE);
        rsp_valid_d = (state_d == ST_RESP);
        rdata_d     = rdata_q;
        err_d       = err_q;
        if (access_now) begin
            err_d   = acc_range_err;
            rdata_d = (acc_write || acc_range_err) ? 32'd0 : rd_word;
        end else if ((state_q == ST_RESP) && RspReady) begin
            rdata_d = 32'd0;
            err_d   = 1'b0;
        end
    end

    assign ReqReady = ready_q;
    assign RspValid = rsp_valid_q;
    assign RspRData = rdata_q;
    assign RspErr   = err_q;

endmodule

// File: tb/tb_data_mem_responder.sv
module tb_data_mem_responder;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;

    logic        req_valid, req_write, rsp_ready;
    logic [31:0] req_addr, req_wdata;
    logic [3:0]  req_strb;
    logic        req_ready, rsp_valid, rsp_err;
    logic [31:0] rsp_rdata;

    logic        req_valid_z, req_write_z, rsp_ready_z;
    logic [31:0] req_addr_z, req_wdata_z;
    logic [3:0]  req_strb_z;
    logic        req_ready_z, rsp_valid_z, rsp_err_z;
    logic [31:0] rsp_rdata_z;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    data_mem_responder #(.ADDR_W(10), .LATENCY(2)) dut (
        .CLK(clk), .RSTn(rst_n),
        .ReqValid(req_valid), .ReqReady(req_ready), .ReqAddr(req_addr),
        .ReqWrite(req_write), .ReqStrb(req_strb), .ReqWData(req_wdata),
        .RspValid(rsp_valid), .RspReady(rsp_ready), .RspRData(rsp_rdata),
        .RspErr(rsp_err)
    );

    data_mem_responder #(.ADDR_W(10), .LATENCY(0)) dut_z (
        .CLK(clk), .RSTn(rst_n),
        .ReqValid(req_valid_z), .ReqReady(req_ready_z), .ReqAddr(req_addr_z),
        .ReqWrite(req_write_z), .ReqStrb(req_strb_z), .ReqWData(req_wdata_z),
        .RspValid(rsp_valid_z), .RspReady(rsp_ready_z), .RspRData(rsp_rdata_z),
        .RspErr(rsp_err_z)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    function automatic logic sel_rv(input bit z);
        return z ? rsp_valid_z : rsp_valid;
    endfunction

    task automatic set_req(input bit z, input logic v, input logic wr, input logic [31:0] a,
                           input logic [3:0] s, input logic [31:0] d);
        if (z) begin
            req_valid_z = v; req_write_z = wr; req_addr_z = a; req_strb_z = s; req_wdata_z = d;
        end else begin
            req_valid = v; req_write = wr; req_addr = a; req_strb = s; req_wdata = d;
        end
    endtask

    // Full access with RspReady already high; called at a negedge while idle.
    task automatic access(input bit z, input string tag, input logic wr, input logic [31:0] a,
                          input logic [3:0] s, input logic [31:0] d,
                          output logic [31:0] rd, output logic er, output int lat);
        int n;
        if (z) rsp_ready_z = 1'b1; else rsp_ready = 1'b1;
        set_req(z, 1'b1, wr, a, s, d);
        @(posedge clk);
        @(negedge clk);
        set_req(z, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
        n = 1;
        while (!sel_rv(z) && n < 20) begin
            @(negedge clk);
            n++;
        end
        lat = n;
        rd  = z ? rsp_rdata_z : rsp_rdata;
        er  = z ? rsp_err_z : rsp_err;
        @(negedge clk);
        check_val({tag, "_rsp_drop"}, 32'(sel_rv(z)), 32'd0);
        check_val({tag, "_ready_back"}, 32'(z ? req_ready_z : req_ready), 32'd1);
    endtask

    logic [31:0] rd;
    logic        er;
    int          lat;
    int          n;

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        set_req(1'b0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
        set_req(1'b1, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
        rsp_ready = 1'b0;
        rsp_ready_z = 1'b0;

        // Reset values
        repeat (3) @(negedge clk);
        check_val("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check_val("rst_rdata", rsp_rdata, 32'd0);
        check_val("rst_err", 32'(rsp_err), 32'd0);
        check_val("rst_z_rsp_valid", 32'(rsp_valid_z), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check_val("rst_ready", 32'(req_ready), 32'd1);

        // Full-word write then read back
        access(0, "wr10", 1'b1, 32'h0000_0010, 4'hF, 32'hDEAD_BEEF, rd, er, lat);
        check_val("wr10_lat", 32'(lat), 32'd3);
        check_val("wr10_rdata", rd, 32'd0);
        check_val("wr10_err", 32'(er), 32'd0);
        access(0, "rd10", 1'b0, 32'h0000_0010, 4'h0, 32'h0, rd, er, lat);
        check_val("rd10_data", rd, 32'hDEAD_BEEF);

        // Single-lane write
        access(0, "wrb2", 1'b1, 32'h0000_0010, 4'b0100, 32'h00AB_0000, rd, er, lat);
        access(0, "rdb2", 1'b0, 32'h0000_0010, 4'h0, 32'h0, rd, er, lat);
        check_val("rdb2_data", rd, 32'hDEAB_BEEF);

        // Zero-strobe write still responds, changes nothing
        access(0, "wrs0", 1'b1, 32'h0000_0010, 4'h0, 32'h1111_2222, rd, er, lat);
        check_val("wrs0_lat", 32'(lat), 32'd3);
        access(0, "rds0", 1'b0, 32'h0000_0010, 4'h0, 32'h0, rd, er, lat);
        check_val("rds0_data", rd, 32'hDEAB_BEEF);

        // Response backpressure; request inputs wiggle while busy
        rsp_ready = 1'b0;
        set_req(0, 1'b1, 1'b0, 32'h0000_0010, 4'h0, 32'h0);
        @(posedge clk);
        @(negedge clk);
        set_req(0, 1'b1, 1'b1, 32'h0000_0010, 4'hF, 32'h0000_0000);
        n = 1;
        while (!rsp_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        check_val("bp_lat", 32'(n), 32'd3);
        for (int i = 0; i < 5; i++) begin
            check_val("bp_valid", 32'(rsp_valid), 32'd1);
            check_val("bp_rdata", rsp_rdata, 32'hDEAB_BEEF);
            check_val("bp_ready_low", 32'(req_ready), 32'd0);
            @(negedge clk);
        end
        set_req(0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
        rsp_ready = 1'b1;
        @(negedge clk);
        check_val("bp_ready_back", 32'(req_ready), 32'd1);
        check_val("bp_valid_drop", 32'(rsp_valid), 32'd0);
        access(0, "rdbp", 1'b0, 32'h0000_0010, 4'h0, 32'h0, rd, er, lat);
        check_val("busy_ignore_data", rd, 32'hDEAB_BEEF);

        // Occupancy: ReqValid held, count cycles until ReqReady again
        set_req(0, 1'b1, 1'b0, 32'h0000_0010, 4'h0, 32'h0);
        @(negedge clk);
        n = 1;
        while (!req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        set_req(0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
        check_val("occupancy", 32'(n), 32'd4);
        @(negedge clk);
        check_val("occ_idle_valid", 32'(rsp_valid), 32'd0);

        // Reset mid-BUSY drops the pending write
        access(0, "wr20z", 1'b1, 32'h0000_0020, 4'hF, 32'h0, rd, er, lat);
        set_req(0, 1'b1, 1'b1, 32'h0000_0020, 4'hF, 32'h1234_5678);
        @(posedge clk);
        @(negedge clk);
        set_req(0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
        rst_n = 1'b0;
        #1;
        check_val("midrst_valid", 32'(rsp_valid), 32'd0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        check_val("midrst_ready", 32'(req_ready), 32'd1);
        check_val("midrst_valid_rel", 32'(rsp_valid), 32'd0);
        access(0, "rd20", 1'b0, 32'h0000_0020, 4'h0, 32'h0, rd, er, lat);
        check_val("rd20_data", rd, 32'd0);
        access(0, "rd10k", 1'b0, 32'h0000_0010, 4'h0, 32'h0, rd, er, lat);
        check_val("mem_kept", rd, 32'hDEAB_BEEF);

        // High address bits: error or wrap depending on build
        access(0, "wr4z", 1'b1, 32'h0000_0004, 4'hF, 32'h0, rd, er, lat);
        access(0, "wrhi", 1'b1, 32'h0000_1004, 4'hF, 32'h5555_5555, rd, er, lat);
        check_val("wrhi_lat", 32'(lat), 32'd3);
        check_val("wrhi_rdata", rd, 32'd0);
`ifdef DMRESP_RANGE_ERR_EN
        check_val("wrhi_err", 32'(er), 32'd1);
        access(0, "rd4", 1'b0, 32'h0000_0004, 4'h0, 32'h0, rd, er, lat);
        check_val("rd4_data", rd, 32'd0);
        check_val("rd4_err", 32'(er), 32'd0);
        access(0, "rdhi", 1'b0, 32'h0000_1010, 4'h0, 32'h0, rd, er, lat);
        check_val("rdhi_err", 32'(er), 32'd1);
        check_val("rdhi_data", rd, 32'd0);
`else
        check_val("wrhi_err", 32'(er), 32'd0);
        access(0, "rd4", 1'b0, 32'h0000_0004, 4'h0, 32'h0, rd, er, lat);
        check_val("rd4_data", rd, 32'h5555_5555);
        access(0, "rdhi", 1'b0, 32'h0000_1010, 4'h0, 32'h0, rd, er, lat);
        check_val("rdhi_wrap", rd, 32'hDEAB_BEEF);
        check_val("rdhi_err", 32'(er), 32'd0);
`endif

        // Zero-latency instance
        access(1, "z_wr", 1'b1, 32'h0000_0008, 4'hF, 32'hCAFE_F00D, rd, er, lat);
        check_val("z_wr_lat", 32'(lat), 32'd1);
        check_val("z_wr_rdata", rd, 32'd0);
        access(1, "z_rd", 1'b0, 32'h0000_0008, 4'h0, 32'h0, rd, er, lat);
        check_val("z_rd_lat", 32'(lat), 32'd1);
        check_val("z_rd_data", rd, 32'hCAFE_F00D);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
